spi_slave: RTL

- SPI target (responder) end of the 4-wire bus driven by the team's SPI master.
- Oversamples sclk, ss_n and mosi on the local system clock.
- Supports all four CPOL/CPHA modes and moves 8-bit frames MSB-first.
- Presents received bytes on a valid-pulse interface and takes transmit bytes through a one-entry ready/valid buffer.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 21 ++
 rtl/spi_slave.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target block.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchronizer with a selectable reset level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= {STAGES{RST_VAL}};
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled sclk/ss_n/mosi, all four modes, MSB-first frames,
// one-entry transmit buffer and a valid-pulse receive interface.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun,
  input  logic              clr_flags
);

  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic w_sclk_s, w_ss_s, w_mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_d(sclk), .o_q(w_sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .i_d(ss_n), .o_q(w_ss_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_d(mosi), .o_q(w_mosi_s));

  state_t              r_state, w_state_nxt;
  logic                r_sclk_prev, r_ss_prev;
  logic [1:0]          r_mode;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-2:0]   r_rx_shift;
  logic [DATA_W-1:0]   r_tx_shift, r_tx_buf, r_rx_data;
  logic                r_tx_full, r_rx_valid, r_miso_oe, r_underrun;

  logic w_ss_fall, w_ss_rise, w_start, w_active;
  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
  logic w_first, w_last, w_load, w_tx_wr;
  logic [DATA_W-1:0] w_rx_nxt, w_load_val;

  assign w_ss_fall = r_ss_prev & ~w_ss_s;
  assign w_ss_rise = ~r_ss_prev & w_ss_s;
  assign w_start   = (r_state == IDLE) & w_ss_fall;
  // An abort in the same cycle as an sclk edge takes priority over the edge.
  assign w_active  = (r_state == ACTIVE) & ~w_ss_rise;

  assign w_rise   = w_sclk_s & ~r_sclk_prev;
  assign w_fall   = ~w_sclk_s & r_sclk_prev;
  assign w_lead   = r_mode[CPOL_BIT] ? w_fall : w_rise;
  assign w_trail  = r_mode[CPOL_BIT] ? w_rise : w_fall;
  assign w_sample = w_active & (r_mode[CPHA_BIT] ? w_trail : w_lead);
  assign w_shift  = w_active & (r_mode[CPHA_BIT] ? w_lead : w_trail);

  assign w_first = (r_bit_cnt == '0);
  assign w_last  = (r_bit_cnt == LAST);

  // A shift edge seen with bit_cnt==0 follows a completed frame (CPHA=0,
  // reload) or is the first leading edge of a frame (CPHA=1, hold bit 7).
  assign w_load = w_start
                | (w_shift  & w_first & ~r_mode[CPHA_BIT])
                | (w_sample & w_last  &  r_mode[CPHA_BIT]);

  assign w_tx_wr    = tx_valid & ~r_tx_full;
  assign w_load_val = r_tx_full ? r_tx_buf : DEFAULT_TX;
  assign w_rx_nxt   = {r_rx_shift, w_mosi_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_ss_fall) w_state_nxt = ACTIVE;
      ACTIVE: if (w_ss_rise) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
      r_mode      <= MODE0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
      r_rx_valid  <= 1'b0;

      if (w_start) begin
        r_mode     <= mode;
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
        r_miso_oe  <= 1'b1;
      end else if ((r_state == ACTIVE) && w_ss_rise) begin
        r_bit_cnt <= '0;
        r_miso_oe <= 1'b0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_nxt[DATA_W-2:0];
        if (w_last) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_nxt;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end

      if (w_load)                  r_tx_shift <= w_load_val;
      else if (w_shift && !w_first) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};

      // A write landing with a load: the load takes the old content first.
      if (w_tx_wr) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end

      if (w_load && !r_tx_full) r_underrun <= 1'b1;
      else if (clr_flags)       r_underrun <= 1'b0;
    end
  end

  assign miso     = (r_state == ACTIVE) ? r_tx_shift[DATA_W-1] : 1'b0;
  assign miso_oe  = r_miso_oe;
  assign tx_ready = ~r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state == ACTIVE);
  assign underrun = r_underrun;

endmodule
